// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word/schedule types, sigma/choice/majority functions, round constants, schedule FSM states.
// Latency: n/a (types, constants and pure combinational functions only).
// Backpressure: n/a.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int ROUNDS      = 64;
  localparam int BLOCK_WORDS = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t [0:ROUNDS-1] sched_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } sched_state_t;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // Message-schedule sigmas (lower case) and compression sigmas (upper case).
  function automatic word_t s0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t s1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t S0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t S1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  localparam sched_t K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/msg_sched_word.sv
// Next schedule word: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] mod 2^32.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: i_w2/i_w7/i_w15/i_w16 = W[t-2]/W[t-7]/W[t-15]/W[t-16]; o_w = W[t].
module msg_sched_word
  import sha256_pkg::*;
(
  input  word_t i_w2,
  input  word_t i_w7,
  input  word_t i_w15,
  input  word_t i_w16,
  output word_t o_w
);

  assign o_w = s1(i_w2) + i_w7 + s0(i_w15) + i_w16;

endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message-schedule expander: loads a 512-bit block, expands W[16..63] one word per cycle, holds W until taken.
// Latency: out_valid 48 cycles after block acceptance; 50-cycle minimum block-to-block period.
// Backpressure: out_ready may stay low forever; W and out_valid hold, in_ready stays low until the schedule is taken.
// Ports: clk, reset_n (sync, active-low); in_valid/in_ready/block_in (word 0 in [511:480]);
//        out_valid/out_ready; W (packed [0:63][31:0]); busy (high while expanding).
// Option: define MSG_SCHEDULE_BSWAP_EN to byte-reverse each loaded word for little-endian producers.
module msg_schedule
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block_in,
  output logic         out_valid,
  input  logic         out_ready,
  output sched_t       W,
  output logic         busy
);

  sched_state_t r_state;
  logic [6:0]   r_t;
  sched_t       r_w;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;

  logic [5:0]   w_i2, w_i7, w_i15, w_i16;
  word_t        w_next;

  function automatic word_t load_word(input word_t x);
`ifdef MSG_SCHEDULE_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  // t is always in 16..63 while expanding, so 6-bit differences never underflow.
  assign w_i2  = r_t[5:0] - 6'd2;
  assign w_i7  = r_t[5:0] - 6'd7;
  assign w_i15 = r_t[5:0] - 6'd15;
  assign w_i16 = r_t[5:0] - 6'd16;

  msg_sched_word u_word (
    .i_w2  (r_w[w_i2]),
    .i_w7  (r_w[w_i7]),
    .i_w15 (r_w[w_i15]),
    .i_w16 (r_w[w_i16]),
    .o_w   (w_next)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_t         <= '0;
      r_w         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
              r_w[i] <= load_word(block_in[(BLOCK_WORDS-1-i)*WORD_W +: WORD_W]);
            end
            r_t        <= 7'(BLOCK_WORDS);
            r_state    <= ST_EXPAND;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_EXPAND: begin
          r_w[r_t[5:0]] <= w_next;
          // out_valid registers alongside the final word so both appear together.
          if (r_t == 7'(ROUNDS-1)) begin
            r_state     <= ST_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_t <= r_t + 7'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign W         = r_w;

endmodule

// File: tb/tb_msg_schedule.sv
module tb_msg_schedule;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic [511:0]       block_in;
  logic               out_valid;
  logic               out_ready;
  logic [0:63][31:0]  w_dut;
  logic               busy;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic        ov_prev = 1'b0;

  always #5 clk = ~clk;

  msg_schedule dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .block_in  (block_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .W         (w_dut),
    .busy      (busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return m_ror(x, 7) ^ m_ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return m_ror(x, 17) ^ m_ror(x, 19) ^ (x >> 10);
  endfunction

  // Word as the producer presents it on block_in, given the intended schedule word.
  function automatic logic [31:0] raw_word(input logic [31:0] x);
`ifdef MSG_SCHEDULE_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  task automatic push_expected(input logic [511:0] b);
    logic [31:0] w [64];
    for (int i = 0; i < 16; i++) w[i] = raw_word(b[511-32*i -: 32]);
    for (int i = 16; i < 64; i++) w[i] = m_s1(w[i-2]) + w[i-7] + m_s0(w[i-15]) + w[i-16];
    for (int i = 0; i < 64; i++) exp_q.push_back(w[i]);
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Scoreboard: each rising out_valid pops one full expected schedule.
  always @(posedge clk) begin
    #1;
    if (out_valid && !ov_prev) begin
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sched_word[%0d]: got %h, no expected schedule queued", i, w_dut[i]);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (w_dut[i] !== e) begin
            errors++;
            $display("FAIL sched_word[%0d]: got %h expected %h", i, w_dut[i], e);
          end
        end
      end
    end
    ov_prev = out_valid;
  end

  // ---------------- stimulus helpers (no checking) ----------------
  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic offer(input logic [511:0] b, output bit ok);
    logic r;
    ok = 1'b0;
    in_valid = 1'b1;
    block_in = b;
    for (int n = 0; n < 200; n++) begin
      r = in_ready;
      @(posedge clk); #1;
      if (r) begin
        ok = 1'b1;
        push_expected(b);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic release_sched();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; block_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (w_dut !== '0) begin errors++; $display("FAIL reset_W: W[0]=%h W[63]=%h expected all zero", w_dut[0], w_dut[63]); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    offer(rand_block(), ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_accept: block not accepted within bound"); end
    repeat (19) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b expected 1", busy); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_after: got %b expected 0", busy); end
    checks++; if (w_dut !== '0) begin errors++; $display("FAIL midrst_W: W[0]=%h W[16]=%h expected all zero", w_dut[0], w_dut[16]); end
    repeat (60) begin @(posedge clk); #1; end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_abc();
    logic [511:0] b;
    bit ok;
    int k;
    b = '0;
    b[511:480] = raw_word(32'h61626380);
    b[31:0]    = raw_word(32'h00000018);
    offer(b, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abc_accept: block not accepted within bound"); end
    checks++; if (w_dut[0] !== 32'h61626380) begin errors++; $display("FAIL abc_W0: got %h expected 61626380", w_dut[0]); end
    wait_valid(k);
    checks++; if (k != 48) begin errors++; $display("FAIL abc_latency: got %0d expected 48", k); end
    checks++; if (w_dut[16] !== 32'h61626380) begin errors++; $display("FAIL abc_W16: got %h expected 61626380", w_dut[16]); end
    checks++; if (w_dut[17] !== 32'h000F0000) begin errors++; $display("FAIL abc_W17: got %h expected 000f0000", w_dut[17]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abc_busy_done: got %b expected 0", busy); end
    release_sched();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL abc_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    checks++; if (w_dut[17] !== 32'h000F0000) begin errors++; $display("FAIL abc_idle_hold: got %h expected 000f0000", w_dut[17]); end
  endtask

  task automatic test_zero();
    bit ok;
    int k;
    offer('0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_accept: block not accepted within bound"); end
    wait_valid(k);
    checks++; if (k != 48) begin errors++; $display("FAIL zero_latency: got %0d expected 48", k); end
    checks++; if (w_dut !== '0) begin errors++; $display("FAIL zero_W: W[16]=%h W[63]=%h expected all zero", w_dut[16], w_dut[63]); end
    release_sched();
  endtask

  task automatic test_backpressure();
    logic [0:63][31:0] snap;
    bit ok;
    int k;
    int bad;
    offer(rand_block(), ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept: block not accepted within bound"); end
    wait_valid(k);
    checks++; if (k != 48) begin errors++; $display("FAIL bp_latency: got %0d expected 48", k); end
    snap = w_dut;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = (i % 7 == 0);
      block_in = rand_block();
      @(posedge clk); #1;
      if (w_dut !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles expected 0", bad); end
    release_sched();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    checks++; if (w_dut !== snap) begin errors++; $display("FAIL bp_idle_hold: W[63]=%h expected %h", w_dut[63], snap[63]); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_accept: busy=%b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] b2;
    int acc [2];
    int n_acc;
    int edges;
    int k;
    logic r;
    b2 = rand_block();
    out_ready = 1'b1;
    in_valid = 1'b1;
    block_in = rand_block();
    n_acc = 0;
    edges = 0;
    for (int n = 0; n < 300 && n_acc < 2; n++) begin
      r = in_ready;
      @(posedge clk); #1;
      edges++;
      if (r) begin
        acc[n_acc] = edges;
        push_expected(block_in);
        n_acc++;
        block_in = b2;
        if (n_acc == 2) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++; if (n_acc != 2) begin errors++; $display("FAIL b2b_accepts: got %0d expected 2", n_acc); end
    else begin
      checks++; if (acc[1] - acc[0] != 50) begin errors++; $display("FAIL b2b_period: got %0d expected 50", acc[1] - acc[0]); end
    end
    wait_valid(k);
    checks++; if (k != 48) begin errors++; $display("FAIL b2b_latency: got %0d expected 48", k); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_reset_mid();
    test_abc();
    test_zero();
    test_backpressure();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #2;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d words left expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
